// File: rtl/bch_dec_chien_search.sv
// Purpose : DEC BCH error locator; scaled locator S1 + S1^2*x + (S3+S1^3)*x^2 searched by Chien.
// Latency : trivial syndromes -> done_o one cycle after accept; otherwise N+1 cycles after accept.
// Backpr. : no stall path; start_i is dropped while busy_o is high, accepted in IDLE or DONE.
module bch_dec_chien_search #(
  parameter int unsigned P_GF_M      = 5,
  parameter logic [8:0]  P_PRIM_POLY = 9'h025,
  parameter int unsigned P_CW_LEN    = 31
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_i,
  input  logic [2*P_GF_M-1:0]        synd_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [(1<<P_GF_M)-2:0]     err_vec_o,
  output logic [1:0]                 err_cnt_o,
  output logic                       uncorr_o
);

  localparam int unsigned LP_M  = P_GF_M;
  localparam int unsigned LP_N  = (1 << P_GF_M) - 1;
  localparam int unsigned LP_JW = $clog2(LP_N + 1);

  // Low m bits of the polynomial give the reduction constant for a multiply by alpha.
  localparam logic [LP_M-1:0]  LP_POLY_LO = P_PRIM_POLY[LP_M-1:0];
  // alpha^-1 = (poly >> 1) because poly(alpha) = 0 and the constant term is 1.
  localparam logic [LP_M-1:0]  LP_AINV    = P_PRIM_POLY[LP_M:1];
  localparam logic [LP_JW-1:0] LP_J_LAST  = LP_JW'(LP_N - 1);
  localparam logic [LP_JW-1:0] LP_CW_LEN  = LP_JW'(P_CW_LEN);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Generic GF(2^m) shift-and-add multiply, reduced by the primitive polynomial.
  function automatic logic [LP_M-1:0] gf_mul(input logic [LP_M-1:0] a, input logic [LP_M-1:0] b);
    logic [LP_M-1:0] acc;
    logic [LP_M-1:0] aa;
    acc = '0;
    aa  = a;
    for (int i = 0; i < int'(LP_M); i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = aa[LP_M-1] ? ({aa[LP_M-2:0], 1'b0} ^ LP_POLY_LO) : {aa[LP_M-2:0], 1'b0};
    end
    return acc;
  endfunction

  // Constant multiply by alpha^-1: shift right, fold the dropped unit term back in.
  function automatic logic [LP_M-1:0] gf_mul_ainv(input logic [LP_M-1:0] v);
    return v[0] ? ({1'b0, v[LP_M-1:1]} ^ LP_AINV) : {1'b0, v[LP_M-1:1]};
  endfunction

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_accept;

  logic [LP_M-1:0]   w_s1;
  logic [LP_M-1:0]   w_s3;
  logic [LP_M-1:0]   w_s1_sq;
  logic [LP_M-1:0]   w_s1_cu;
  logic [LP_M-1:0]   w_t;

  logic [LP_M-1:0]   r_r0;
  logic [LP_M-1:0]   r_r1;
  logic [LP_M-1:0]   r_r2;
  logic [LP_JW-1:0]  r_j;
  logic [LP_N-1:0]   r_vec;
  logic [1:0]        r_cnt;
  logic              r_ill;
  logic              r_t_zero;

  logic              w_last;
  logic              w_hit;
  logic [LP_N-1:0]   w_vec_nxt;
  logic [1:0]        w_cnt_nxt;
  logic              w_ill_nxt;
  logic [1:0]        w_exp;
  logic              w_bad;

  logic [LP_N-1:0]   r_err_vec;
  logic [1:0]        r_err_cnt;
  logic              r_uncorr;

  assign w_s1    = synd_i[LP_M-1:0];
  assign w_s3    = synd_i[2*LP_M-1:LP_M];
  assign w_s1_sq = gf_mul(w_s1, w_s1);
  assign w_s1_cu = gf_mul(w_s1_sq, w_s1);
  assign w_t     = w_s3 ^ w_s1_cu;

  // Position j is a root when L(alpha^-j) sums to zero.
  assign w_last    = (r_j == LP_J_LAST);
  assign w_hit     = ((r_r0 ^ r_r1 ^ r_r2) == '0);
  assign w_vec_nxt = r_vec | ({{(LP_N-1){1'b0}}, w_hit} << r_j);
  assign w_cnt_nxt = (w_hit && (r_cnt != 2'd3)) ? (r_cnt + 2'd1) : r_cnt;
  assign w_ill_nxt = r_ill | (w_hit && (r_j >= LP_CW_LEN));
  // T == 0 means a single error (degree-1 locator), otherwise two roots are required.
  assign w_exp     = r_t_zero ? 2'd1 : 2'd2;
  assign w_bad     = (w_cnt_nxt != w_exp) || (w_cnt_nxt == 2'd3) || w_ill_nxt;

  assign busy_o    = (r_state == ST_SEARCH);
  assign done_o    = (r_state == ST_DONE);
  assign err_vec_o = r_err_vec;
  assign err_cnt_o = r_err_cnt;
  assign uncorr_o  = r_uncorr;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and accept decode; a zero S1 never needs a search.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          w_accept    = 1'b1;
          w_state_nxt = (w_s1 == '0) ? ST_DONE : ST_SEARCH;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SEARCH: begin
        if (w_last) w_state_nxt = ST_DONE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Search datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_r0      <= '0;
      r_r1      <= '0;
      r_r2      <= '0;
      r_j       <= '0;
      r_vec     <= '0;
      r_cnt     <= 2'd0;
      r_ill     <= 1'b0;
      r_t_zero  <= 1'b0;
      r_err_vec <= '0;
      r_err_cnt <= 2'd0;
      r_uncorr  <= 1'b0;
    end else if (w_accept) begin
      r_r0      <= w_s1;
      r_r1      <= w_s1_sq;
      r_r2      <= w_t;
      r_j       <= '0;
      r_vec     <= '0;
      r_cnt     <= 2'd0;
      r_ill     <= 1'b0;
      r_t_zero  <= (w_t == '0);
      r_err_vec <= '0;
      r_err_cnt <= 2'd0;
      // S1 = 0 with S3 != 0 cannot come from one or two errors.
      r_uncorr  <= (w_s1 == '0) && (w_s3 != '0);
    end else if (r_state == ST_SEARCH) begin
      r_vec <= w_vec_nxt;
      r_cnt <= w_cnt_nxt;
      r_ill <= w_ill_nxt;
      r_r1  <= gf_mul_ainv(r_r1);
      r_r2  <= gf_mul_ainv(gf_mul_ainv(r_r2));
      if (w_last) begin
        r_uncorr  <= w_bad;
        r_err_vec <= w_bad ? '0 : w_vec_nxt;
        r_err_cnt <= w_bad ? 2'd0 : w_exp;
      end else begin
        r_j <= r_j + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bch_dec_chien_search.sv
// Purpose : directed checks of the DEC BCH Chien search (m=5, N=31) full and shortened.
// Latency : cycle counts measured from the accepting edge.
// Backpr. : start pulses during a search must be dropped.
module tb_bch_dec_chien_search;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_start, b_start;
  logic [9:0]  a_synd, b_synd;
  logic        a_busy, a_done, a_unc;
  logic        b_busy, b_done, b_unc;
  logic [30:0] a_vec, b_vec;
  logic [1:0]  a_cnt, b_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bch_dec_chien_search #(.P_GF_M(5), .P_PRIM_POLY(9'h025), .P_CW_LEN(31)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(a_start), .synd_i(a_synd),
    .busy_o(a_busy), .done_o(a_done), .err_vec_o(a_vec), .err_cnt_o(a_cnt), .uncorr_o(a_unc)
  );

  bch_dec_chien_search #(.P_GF_M(5), .P_PRIM_POLY(9'h025), .P_CW_LEN(26)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(b_start), .synd_i(b_synd),
    .busy_o(b_busy), .done_o(b_done), .err_vec_o(b_vec), .err_cnt_o(b_cnt), .uncorr_o(b_unc)
  );

  // alpha^e in GF(32), x^5+x^2+1, by repeated multiply by alpha.
  function automatic logic [4:0] apow(input int e);
    logic [4:0] v;
    v = 5'd1;
    for (int k = 0; k < (e % 31); k++)
      v = v[4] ? ({v[3:0], 1'b0} ^ 5'h05) : {v[3:0], 1'b0};
    return v;
  endfunction

  // Syndromes {S3,S1} of an error pattern (a codeword contributes zero).
  function automatic logic [9:0] synd_of(input logic [30:0] ev);
    logic [4:0] s1, s3;
    s1 = 5'd0;
    s3 = 5'd0;
    for (int i = 0; i < 31; i++)
      if (ev[i]) begin
        s1 = s1 ^ apow(i);
        s3 = s3 ^ apow(3 * i);
      end
    return {s3, s1};
  endfunction

  // Pulse start for one cycle and wait for done; lat = cycles from accept edge (k+lat).
  task automatic run_dec(input bit sel, input logic [9:0] synd, output int lat);
    if (sel) begin b_start = 1'b1; b_synd = synd; end
    else     begin a_start = 1'b1; a_synd = synd; end
    @(posedge clk); #1;
    a_start = 1'b0;
    b_start = 1'b0;
    lat = 1;
    while (!(sel ? b_done : a_done) && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if ({a_busy, a_done, a_vec, a_cnt, a_unc} !== 36'h0) begin
      n_errors++;
      $display("FAIL reset_a: got %h expected 0", {a_busy, a_done, a_vec, a_cnt, a_unc});
    end
    n_checks++;
    if ({b_busy, b_done, b_vec, b_cnt, b_unc} !== 36'h0) begin
      n_errors++;
      $display("FAIL reset_b: got %h expected 0", {b_busy, b_done, b_vec, b_cnt, b_unc});
    end
  endtask

  task automatic test_no_error();
    int lat;
    run_dec(1'b0, 10'h000, lat);
    n_checks++;
    if (lat !== 1) begin n_errors++; $display("FAIL noerr_lat: got %0d expected 1", lat); end
    n_checks++;
    if ({a_vec, a_cnt, a_unc} !== {31'h0, 2'd0, 1'b0}) begin
      n_errors++;
      $display("FAIL noerr_res: got vec=%h cnt=%0d unc=%b expected 0/0/0", a_vec, a_cnt, a_unc);
    end
  endtask

  task automatic test_single();
    int lat;
    run_dec(1'b0, synd_of(31'h8), lat);
    n_checks++;
    if (lat !== 32) begin n_errors++; $display("FAIL single_lat: got %0d expected 32", lat); end
    n_checks++;
    if ({a_vec, a_cnt, a_unc} !== {31'h8, 2'd1, 1'b0}) begin
      n_errors++;
      $display("FAIL single_res: got vec=%h cnt=%0d unc=%b expected 8/1/0", a_vec, a_cnt, a_unc);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({a_done, a_vec, a_cnt, a_unc} !== {1'b0, 31'h8, 2'd1, 1'b0}) begin
      n_errors++;
      $display("FAIL single_hold: got done=%b vec=%h cnt=%0d expected 0/8/1", a_done, a_vec, a_cnt);
    end
  endtask

  task automatic test_double();
    logic [30:0] tbl [3];
    int lat;
    tbl[0] = 31'h40000001;
    tbl[1] = (31'd1 << 5) | (31'd1 << 6);
    tbl[2] = (31'd1 << 12) | (31'd1 << 25);
    for (int t = 0; t < 3; t++) begin
      run_dec(1'b0, synd_of(tbl[t]), lat);
      n_checks++;
      if (lat !== 32) begin n_errors++; $display("FAIL double%0d_lat: got %0d expected 32", t, lat); end
      n_checks++;
      if ({a_vec, a_cnt, a_unc} !== {tbl[t], 2'd2, 1'b0}) begin
        n_errors++;
        $display("FAIL double%0d_res: got vec=%h cnt=%0d unc=%b expected %h/2/0",
                 t, a_vec, a_cnt, a_unc, tbl[t]);
      end
    end
  endtask

  task automatic test_forced_uncorr();
    int lat;
    run_dec(1'b0, {5'd1, 5'd0}, lat);
    n_checks++;
    if (lat !== 1) begin n_errors++; $display("FAIL forced_lat: got %0d expected 1", lat); end
    n_checks++;
    if ({a_vec, a_cnt, a_unc} !== {31'h0, 2'd0, 1'b1}) begin
      n_errors++;
      $display("FAIL forced_res: got vec=%h cnt=%0d unc=%b expected 0/0/1", a_vec, a_cnt, a_unc);
    end
  endtask

  // S1=1,S3=0 gives L = 1+x+x^2, which has no roots in GF(2^5).
  task automatic test_no_roots();
    int lat;
    run_dec(1'b0, {5'd0, 5'd1}, lat);
    n_checks++;
    if (lat !== 32) begin n_errors++; $display("FAIL noroot_lat: got %0d expected 32", lat); end
    n_checks++;
    if ({a_vec, a_cnt, a_unc} !== {31'h0, 2'd0, 1'b1}) begin
      n_errors++;
      $display("FAIL noroot_res: got vec=%h cnt=%0d unc=%b expected 0/0/1", a_vec, a_cnt, a_unc);
    end
  endtask

  task automatic test_shortened();
    int lat;
    run_dec(1'b1, synd_of(31'd1 << 28), lat);
    n_checks++;
    if (lat !== 32) begin n_errors++; $display("FAIL short28_lat: got %0d expected 32", lat); end
    n_checks++;
    if ({b_vec, b_cnt, b_unc} !== {31'h0, 2'd0, 1'b1}) begin
      n_errors++;
      $display("FAIL short28_res: got vec=%h cnt=%0d unc=%b expected 0/0/1", b_vec, b_cnt, b_unc);
    end
    run_dec(1'b1, synd_of(31'd1 << 25), lat);
    n_checks++;
    if ({b_vec, b_cnt, b_unc} !== {31'd1 << 25, 2'd1, 1'b0}) begin
      n_errors++;
      $display("FAIL short25_res: got vec=%h cnt=%0d unc=%b expected 2000000/1/0", b_vec, b_cnt, b_unc);
    end
  endtask

  task automatic test_start_while_busy();
    int lat;
    a_start = 1'b1;
    a_synd  = synd_of(31'h40000001);
    @(posedge clk); #1;
    a_start = 1'b0;
    lat = 1;
    n_checks++;
    if (a_busy !== 1'b1) begin n_errors++; $display("FAIL busy_high: got %b expected 1", a_busy); end
    repeat (10) begin @(posedge clk); #1; lat++; end
    a_start = 1'b1;
    a_synd  = 10'h000;
    @(posedge clk); #1;
    lat++;
    a_start = 1'b0;
    while (!a_done && lat < 100) begin @(posedge clk); #1; lat++; end
    n_checks++;
    if (lat !== 32) begin n_errors++; $display("FAIL ignore_lat: got %0d expected 32", lat); end
    n_checks++;
    if ({a_vec, a_cnt, a_unc} !== {31'h40000001, 2'd2, 1'b0}) begin
      n_errors++;
      $display("FAIL ignore_res: got vec=%h cnt=%0d unc=%b expected 40000001/2/0", a_vec, a_cnt, a_unc);
    end
  endtask

  task automatic test_reset_mid_search();
    int lat;
    bit seen;
    a_start = 1'b1;
    a_synd  = synd_of(31'h40000001);
    @(posedge clk); #1;
    a_start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({a_busy, a_done, a_vec, a_cnt, a_unc} !== 36'h0) begin
      n_errors++;
      $display("FAIL midrst_clear: got %h expected 0", {a_busy, a_done, a_vec, a_cnt, a_unc});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (a_done) seen = 1'b1; end
    n_checks++;
    if (seen !== 1'b0) begin n_errors++; $display("FAIL midrst_nodone: got %b expected 0", seen); end
    run_dec(1'b0, synd_of(31'd1 << 9), lat);
    n_checks++;
    if ({lat[7:0], a_vec, a_cnt, a_unc} !== {8'd32, 31'd1 << 9, 2'd1, 1'b0}) begin
      n_errors++;
      $display("FAIL midrst_rerun: got lat=%0d vec=%h cnt=%0d unc=%b expected 32/200/1/0",
               lat, a_vec, a_cnt, a_unc);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [30:0] ev1;
    ev1 = (31'd1 << 5) | (31'd1 << 6);
    run_dec(1'b0, synd_of(ev1), lat);
    a_start = 1'b1;
    a_synd  = synd_of(31'd1 << 9);
    n_checks++;
    if ({a_done, a_vec, a_cnt} !== {1'b1, ev1, 2'd2}) begin
      n_errors++;
      $display("FAIL b2b_first: got done=%b vec=%h cnt=%0d expected 1/%h/2", a_done, a_vec, a_cnt, ev1);
    end
    @(posedge clk); #1;
    a_start = 1'b0;
    lat = 1;
    n_checks++;
    if ({a_busy, a_done, a_vec} !== {1'b1, 1'b0, 31'h0}) begin
      n_errors++;
      $display("FAIL b2b_accept: got busy=%b done=%b vec=%h expected 1/0/0", a_busy, a_done, a_vec);
    end
    while (!a_done && lat < 100) begin @(posedge clk); #1; lat++; end
    n_checks++;
    if ({lat[7:0], a_vec, a_cnt, a_unc} !== {8'd32, 31'd1 << 9, 2'd1, 1'b0}) begin
      n_errors++;
      $display("FAIL b2b_second: got lat=%0d vec=%h cnt=%0d unc=%b expected 32/200/1/0",
               lat, a_vec, a_cnt, a_unc);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    a_start = 1'b0;
    b_start = 1'b0;
    a_synd  = 10'h0;
    b_synd  = 10'h0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_no_error();
    test_single();
    test_double();
    test_forced_uncorr();
    test_no_roots();
    test_shortened();
    test_start_while_busy();
    @(posedge clk); #1;
    test_reset_mid_search();
    @(posedge clk); #1;
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
